pc_fetch_stage: RTL and testbench
=================================

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, instruction injected into IF/ID on reset or flush.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 next_pc  input  32  next PC from the PC-select mux.
REQ-006 stall  input  1  downstream hazard; hold IF/ID and PC.
REQ-007 flush  input  1  redirect; kill the current fetch and the IF/ID contents.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  32  word-aligned fetch address.
REQ-010 imem_ready  input  1  response valid; imem_rdata is sampled in that same cycle.
REQ-011 imem_rdata  input  32  fetched instruction.
REQ-012 pc  output  32  current PC register.
REQ-013 pc_plus4  output  32  pc + 4, combinational; drives the mux PC+4 input.
REQ-014 if_id_pc, if_id_pc_plus4, if_id_instr  output  32 each  IF/ID pipeline register.
REQ-015 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-016 misalign_err  output  1  sticky flag: a misaligned next_pc was accepted.

Function
REQ-017 The block SHALL implement a three-state FSM: REQ (fetch outstanding), BUF (instruction held in the skid buffer), DISCARD (flushed fetch still outstanding).
REQ-018 imem_req SHALL be 1 in REQ and DISCARD, and 0 in BUF.
REQ-019 imem_addr SHALL equal pc in REQ and SHALL equal the captured discard_addr in DISCARD; it SHALL remain stable until imem_ready.
REQ-020 In REQ with imem_ready=1 and stall=0, the block SHALL load IF/ID with {pc, pc+4, imem_rdata, valid=1}, load pc with next_pc, and stay in REQ (zero-wait throughput of 1 instruction per cycle).
REQ-021 In REQ with imem_ready=1 and stall=1, the block SHALL capture imem_rdata into the skid buffer, hold pc and IF/ID, and go to BUF.
REQ-022 In REQ with imem_ready=0, pc and IF/ID SHALL hold.
REQ-023 In BUF with stall=0, the block SHALL load IF/ID from the skid buffer (with pc, pc+4), load pc with next_pc, and go to REQ; in BUF with stall=1, it SHALL hold.
REQ-024 In DISCARD with imem_ready=1, the block SHALL drop the response and go to REQ without changing pc.
REQ-025 Flush SHALL take priority over stall, in every state:
- set IF/ID to {0, 0, NOP_INSTR, valid=0};
- load pc with next_pc;
- drop the skid buffer.
REQ-026 Flush state transitions:
- REQ with imem_ready=0: capture the old pc into discard_addr, then go to DISCARD;
- REQ with imem_ready=1: go to REQ;
- BUF: go to REQ;
- DISCARD: stay in DISCARD unless imem_ready=1.
REQ-027 Every pc load SHALL write {next_pc[31:2], 2'b00}; if next_pc[1:0] != 0, misalign_err SHALL set and remain set until reset.
REQ-028 pc + 4 SHALL be computed modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL reset to:
- pc = RESET_PC;
- FSM = REQ;
- IF/ID = {0, 0, NOP_INSTR, 0};
- misalign_err = 0;
- skid buffer and discard_addr = 0.
REQ-030 rst SHALL override flush, stall and an in-flight fetch; any response arriving during reset SHALL be dropped.

Structure
REQ-031 RESET_PC, NOP_INSTR and the FSM state encodings (2-bit) SHALL live in a shared processor constants package/include file.
REQ-032 The IF/ID register SHALL be a sub-module if_id_reg with load, flush, and hold controls.

Verification
REQ-033 Reset release, imem_ready held at 1, next_pc = pc_plus4 -> imem_addr steps 0, 4, 8, 12 on consecutive cycles; if_id_valid = 1 from the 2nd cycle.
REQ-034 imem_ready delayed 3 cycles -> imem_addr stays 0x0 and imem_req stays 1 for 3 cycles; IF/ID loads only on the ready cycle.
REQ-035 stall=1 on a ready cycle with rdata=0x00500093 -> FSM goes to BUF and imem_req=0; after stall drops, if_id_instr = 0x00500093 and pc advances.
REQ-036 flush with next_pc=0x100 while a fetch at 0x20 is pending -> imem_addr stays 0x20 until ready; that response is dropped; the next request uses 0x100; if_id_valid=0.
REQ-037 flush and stall asserted together in BUF -> flush wins: IF/ID = NOP, pc = next_pc, FSM = REQ.
REQ-038 next_pc = 0x102 -> pc = 0x100 and misalign_err = 1 until rst; pc = 0xFFFF_FFFC -> pc_plus4 = 0x0.

Source files
------------

// File: rtl/pc_fetch_stage_pkg.sv
// Shared processor constants for the fetch stage: reset PC, NOP encoding and
// the fetch FSM state encoding.
package pc_fetch_stage_pkg;

   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_REQ     = 2'b00,
      ST_BUF     = 2'b01,
      ST_DISCARD = 2'b10
   } fetch_state_e;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush (or reset) injects a NOP bubble, load writes
// a new instruction unless hold is asserted.
module if_id_reg
   import pc_fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        flush_i,
   input  logic        hold_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] pc_plus4_i,
   input  logic [31:0] instr_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] instr_o,
   output logic        valid_o
);

   logic [31:0] pc_q, pc_plus4_q, instr_q;
   logic        valid_q;

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         pc_q       <= '0;
         pc_plus4_q <= '0;
         instr_q    <= NOP_INSTR;
         valid_q    <= 1'b0;
      end else if (load_i && !hold_i) begin
         pc_q       <= pc_i;
         pc_plus4_q <= pc_plus4_i;
         instr_q    <= instr_i;
         valid_q    <= 1'b1;
      end
   end

   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_plus4_q;
   assign instr_o    = instr_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: PC register, single-entry skid buffer for stalls,
// and a discard state that swallows the response of a fetch killed by flush.
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] next_pc,
   input  logic        stall,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic        misalign_err
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  skid_q, skid_d;
   logic [31:0]  discard_addr_q, discard_addr_d;
   logic         misalign_q, misalign_d;
   logic         pc_load;
   logic         ifid_load;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      skid_d         = skid_q;
      discard_addr_d = discard_addr_q;
      misalign_d     = misalign_q;
      pc_load        = 1'b0;

      if (flush) begin
         pc_load = 1'b1;
         skid_d  = '0;
         case (state_q)
            ST_REQ: begin
               // The killed fetch is still in flight; remember where it went.
               if (!imem_ready) begin
                  discard_addr_d = pc_q;
                  state_d        = ST_DISCARD;
               end
            end
            ST_BUF:     state_d = ST_REQ;
            ST_DISCARD: if (imem_ready) state_d = ST_REQ;
            default:    state_d = ST_REQ;
         endcase
      end else begin
         case (state_q)
            ST_REQ: begin
               if (imem_ready) begin
                  if (stall) begin
                     skid_d  = imem_rdata;
                     state_d = ST_BUF;
                  end else begin
                     pc_load = 1'b1;
                  end
               end
            end
            ST_BUF: begin
               if (!stall) begin
                  pc_load = 1'b1;
                  state_d = ST_REQ;
               end
            end
            ST_DISCARD: if (imem_ready) state_d = ST_REQ;
            default:    state_d = ST_REQ;
         endcase
      end

      if (pc_load) begin
         pc_d = align_word(next_pc);
         if (next_pc[1:0] != 2'b00) misalign_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_REQ;
         pc_q           <= RESET_PC;
         skid_q         <= '0;
         discard_addr_q <= '0;
         misalign_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         skid_q         <= skid_d;
         discard_addr_q <= discard_addr_d;
         misalign_q     <= misalign_d;
      end
   end

   assign ifid_load = ((state_q == ST_REQ) && imem_ready) || (state_q == ST_BUF);

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ifid_load),
      .flush_i    (flush),
      .hold_i     (stall),
      .pc_i       (pc_q),
      .pc_plus4_i (pc_plus4),
      .instr_i    ((state_q == ST_BUF) ? skid_q : imem_rdata),
      .pc_o       (if_id_pc),
      .pc_plus4_o (if_id_pc_plus4),
      .instr_o    (if_id_instr),
      .valid_o    (if_id_valid)
   );

   assign imem_req     = (state_q != ST_BUF);
   assign imem_addr    = (state_q == ST_DISCARD) ? discard_addr_q : pc_q;
   assign pc           = pc_q;
   assign pc_plus4     = pc_q + 32'd4;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_pc_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] next_pc = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] pc, pc_plus4, if_id_pc, if_id_pc_plus4, if_id_instr;
   logic        if_id_valid, misalign_err;

   int checks = 0;
   int errors = 0;

   pc_fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .next_pc        (next_pc),
      .stall          (stall),
      .flush          (flush),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .pc             (pc),
      .pc_plus4       (pc_plus4),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_instr    (if_id_instr),
      .if_id_valid    (if_id_valid),
      .misalign_err   (misalign_err)
   );

   always #5 clk = ~clk;

   // Behavioural model: the fetch unit either has a word parked awaiting the
   // decoder (m_held), is waiting out a killed fetch (m_discard), or is fetching.
   logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_held_instr, m_daddr;
   bit          m_valid, m_mis, m_held, m_discard;

   task automatic model_load_pc();
      m_pc = next_pc & 32'hFFFF_FFFC;
      if (next_pc % 4 != 0) m_mis = 1'b1;
   endtask

   task automatic model_step();
      if (rst) begin
         m_pc = 32'h0; m_ifpc = 0; m_ifpc4 = 0; m_instr = NOP; m_valid = 0;
         m_mis = 0; m_held = 0; m_held_instr = 0; m_discard = 0; m_daddr = 0;
      end else if (flush) begin
         m_ifpc = 0; m_ifpc4 = 0; m_instr = NOP; m_valid = 0;
         if (m_held) m_held = 0;
         else if (m_discard) begin
            if (imem_ready) m_discard = 0;
         end else if (!imem_ready) begin
            m_discard = 1; m_daddr = m_pc;
         end
         model_load_pc();
      end else if (m_held) begin
         if (!stall) begin
            m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_instr = m_held_instr; m_valid = 1;
            m_held = 0;
            model_load_pc();
         end
      end else if (m_discard) begin
         if (imem_ready) m_discard = 0;
      end else if (imem_ready) begin
         if (stall) begin
            m_held = 1; m_held_instr = imem_rdata;
         end else begin
            m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_instr = imem_rdata; m_valid = 1;
            model_load_pc();
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("imem_req", {31'b0, imem_req}, {31'b0, !m_held});
      chk("imem_addr", imem_addr, m_discard ? m_daddr : m_pc);
      chk("if_id_pc", if_id_pc, m_ifpc);
      chk("if_id_pc_plus4", if_id_pc_plus4, m_ifpc4);
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
   endtask

   task automatic step(input bit r, input bit s, input bit f, input bit rdy,
                       input logic [31:0] np, input logic [31:0] rd);
      @(negedge clk);
      rst = r; stall = s; flush = f; imem_ready = rdy; next_pc = np; imem_rdata = rd;
      @(posedge clk);
      model_step();
      #1;
   endtask

   typedef struct {
      bit          rst, stall, flush, ready;
      logic [31:0] next_pc, rdata;
      bit          e_req;
      logic [31:0] e_addr, e_pc;
      bit          e_valid;
      logic [31:0] e_instr;
      bit          e_mis;
   } vec_t;

   vec_t tbl[10];

   initial begin
      logic [31:0] np;
      // Zero-wait streaming, then a delayed response.
      tbl[0] = '{1'b1,1'b0,1'b0,1'b0, 32'h0,   32'h0,        1'b1, 32'h0, 32'h0, 1'b0, NOP,          1'b0};
      tbl[1] = '{1'b0,1'b0,1'b0,1'b1, 32'h4,   32'hA000_0001,1'b1, 32'h4, 32'h4, 1'b1, 32'hA000_0001,1'b0};
      tbl[2] = '{1'b0,1'b0,1'b0,1'b1, 32'h8,   32'hA000_0002,1'b1, 32'h8, 32'h8, 1'b1, 32'hA000_0002,1'b0};
      tbl[3] = '{1'b0,1'b0,1'b0,1'b1, 32'hC,   32'hA000_0003,1'b1, 32'hC, 32'hC, 1'b1, 32'hA000_0003,1'b0};
      tbl[4] = '{1'b1,1'b0,1'b0,1'b1, 32'h40,  32'hEEEE_EEEE,1'b1, 32'h0, 32'h0, 1'b0, NOP,          1'b0};
      tbl[5] = '{1'b0,1'b0,1'b0,1'b0, 32'h4,   32'hBAD0_0001,1'b1, 32'h0, 32'h0, 1'b0, NOP,          1'b0};
      tbl[6] = '{1'b0,1'b0,1'b0,1'b0, 32'h4,   32'hBAD0_0002,1'b1, 32'h0, 32'h0, 1'b0, NOP,          1'b0};
      tbl[7] = '{1'b0,1'b0,1'b0,1'b0, 32'h4,   32'hBAD0_0003,1'b1, 32'h0, 32'h0, 1'b0, NOP,          1'b0};
      tbl[8] = '{1'b0,1'b0,1'b0,1'b1, 32'h4,   32'hB000_0000,1'b1, 32'h4, 32'h4, 1'b1, 32'hB000_0000,1'b0};
      tbl[9] = '{1'b0,1'b0,1'b0,1'b0, 32'h8,   32'h0,        1'b1, 32'h4, 32'h4, 1'b1, 32'hB000_0000,1'b0};

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].ready, tbl[i].next_pc, tbl[i].rdata);
         chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
         chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
         chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
         chk($sformatf("tbl%0d_valid", i), {31'b0, if_id_valid}, {31'b0, tbl[i].e_valid});
         chk($sformatf("tbl%0d_instr", i), if_id_instr, tbl[i].e_instr);
         chk($sformatf("tbl%0d_mis", i), {31'b0, misalign_err}, {31'b0, tbl[i].e_mis});
      end
      chk("tbl_ifpc", if_id_pc, 32'h0);

      // Stall on a ready cycle parks the word; it reaches IF/ID once stall drops.
      step(0, 1, 0, 1, 32'h8, 32'h0050_0093);
      chk("skid_req", {31'b0, imem_req}, 32'd0);
      chk("skid_pc_hold", pc, 32'h4);
      compare_model();
      step(0, 1, 0, 1, 32'h8, 32'h1234_5678);
      chk("skid_still_req", {31'b0, imem_req}, 32'd0);
      step(0, 0, 0, 0, 32'h8, 32'h0);
      chk("skid_instr", if_id_instr, 32'h0050_0093);
      chk("skid_ifpc", if_id_pc, 32'h4);
      chk("skid_pc_adv", pc, 32'h8);
      compare_model();

      // Flush while the fetch at 0x20 is outstanding.
      step(0, 0, 1, 1, 32'h20, 32'h0);
      chk("fl_pc20", pc, 32'h20);
      step(0, 0, 1, 0, 32'h100, 32'h0);
      chk("fl_addr_hold", imem_addr, 32'h20);
      chk("fl_pc", pc, 32'h100);
      chk("fl_valid", {31'b0, if_id_valid}, 32'd0);
      step(0, 0, 0, 0, 32'h999, 32'h0);
      chk("fl_addr_hold2", imem_addr, 32'h20);
      chk("fl_req", {31'b0, imem_req}, 32'd1);
      step(0, 0, 0, 1, 32'h300, 32'hDEAD_BEEF);
      chk("fl_drop_valid", {31'b0, if_id_valid}, 32'd0);
      chk("fl_newaddr", imem_addr, 32'h100);
      chk("fl_pc_keep", pc, 32'h100);
      compare_model();
      step(0, 0, 0, 1, 32'h104, 32'h0000_0011);
      chk("fl_after_ifpc", if_id_pc, 32'h100);
      chk("fl_after_instr", if_id_instr, 32'h0000_0011);
      compare_model();

      // Flush and stall together while holding a skid word.
      step(0, 1, 0, 1, 32'h108, 32'h0000_0022);
      chk("fs_buf_req", {31'b0, imem_req}, 32'd0);
      step(0, 1, 1, 0, 32'h200, 32'h0);
      chk("fs_instr", if_id_instr, NOP);
      chk("fs_valid", {31'b0, if_id_valid}, 32'd0);
      chk("fs_pc", pc, 32'h200);
      chk("fs_req", {31'b0, imem_req}, 32'd1);
      chk("fs_addr", imem_addr, 32'h200);
      compare_model();

      // Misaligned redirect, sticky error, and PC wrap.
      step(0, 0, 0, 1, 32'h102, 32'h0000_0033);
      chk("mis_pc", pc, 32'h100);
      chk("mis_set", {31'b0, misalign_err}, 32'd1);
      step(0, 0, 0, 1, 32'h104, 32'h0000_0034);
      chk("mis_sticky", {31'b0, misalign_err}, 32'd1);
      step(0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0);
      chk("wrap_pc", pc, 32'hFFFF_FFFC);
      chk("wrap_plus4", pc_plus4, 32'h0);
      step(0, 0, 0, 1, 32'h0, 32'h0);
      step(0, 0, 0, 1, 32'h0, 32'h0000_0044);
      chk("wrap_ifpc4", if_id_pc_plus4, 32'h0);
      chk("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
      compare_model();
      step(1, 1, 1, 1, 32'h500, 32'h0000_0055);
      chk("rst_pc", pc, 32'h0);
      chk("rst_mis", {31'b0, misalign_err}, 32'd0);
      chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
      chk("rst_instr", if_id_instr, NOP);
      compare_model();

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         np = $urandom;
         if ($urandom_range(0, 9) != 0) np[1:0] = 2'b00;
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6, np, $urandom);
         compare_model();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
